ttl_74259_sync: RTL and testbench

Synchronous, parametrised addressable latch modelled on the 74LS259, the stateful successor to the `ttl_74138` family decoders. A WIDTH_OUT-bit output register has each bit individually addressed by `A` and written from `D`. There are four modes selected by `Enable_bar` and `Clear_bar`: addressable latch, memory, demultiplexer and clear. The block is clocked on the system clock and qualified by a clock enable. It replaces the board's asynchronous '259 control latches, such as sound, flip-screen and coin-counter latches, without the glitches those parts cause in FPGA fabric.

---
 rtl/ttl_74259_sync.sv | 45 ++++
 tb/tb_ttl_74259_sync.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ttl_74259_sync.sv
// ttl_74259_sync: clocked 74LS259-style addressable latch with latch/memory/demux/clear modes
module ttl_74259_sync #(
    parameter int                   WIDTH_OUT = 8,
    parameter int                   WIDTH_IN  = $clog2(WIDTH_OUT),
    parameter logic [WIDTH_OUT-1:0] INIT      = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cen,
    input  logic                 Enable_bar,
    input  logic                 Clear_bar,
    input  logic [WIDTH_IN-1:0]  A,
    input  logic                 D,
    output logic [WIDTH_OUT-1:0] Q,
    output logic [WIDTH_OUT-1:0] Q_chg,
    output logic [1:0]           mode
);
    logic [WIDTH_OUT-1:0] sel;
    logic [WIDTH_OUT-1:0] q_next;
    logic [1:0]           mode_next;

    // one-hot bit select (empty for out-of-range addresses) and next-state per mode
    always_comb begin
        sel       = (32'(A) < WIDTH_OUT) ? (WIDTH_OUT'(1) << A) : '0;
        mode_next = {~Clear_bar, Enable_bar ^ Clear_bar};
        q_next    = Enable_bar ? (Clear_bar ? Q : '0)
                  : Clear_bar  ? (D ? (Q | sel) : (Q & ~sel))
                  : (D ? sel : '0);
    end

    // registered outputs; change flags last one cycle and clear on any non-enabled edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q     <= INIT;
            Q_chg <= '0;
            mode  <= 2'd0;
        end else if (cen) begin
            Q     <= q_next;
            Q_chg <= q_next ^ Q;
            mode  <= mode_next;
        end else begin
            Q_chg <= '0;
        end
    end
endmodule

// File: tb/tb_ttl_74259_sync.sv
// tb_ttl_74259_sync: directed self-checking bench for the 8-bit and 6-bit addressable latch
module tb_ttl_74259_sync;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cen = 1'b0;
    logic       eb = 1'b1;
    logic       cb = 1'b1;
    logic [2:0] a = '0;
    logic       d = 1'b0;
    logic [7:0] q8, chg8;
    logic [5:0] q6, chg6;
    logic [1:0] mode8, mode6;
    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         total = 0;
    logic [7:0] exp_q;

    ttl_74259_sync #(.WIDTH_OUT(8), .INIT(8'hA5)) u8 (
        .clk(clk), .reset(reset), .cen(cen), .Enable_bar(eb), .Clear_bar(cb),
        .A(a), .D(d), .Q(q8), .Q_chg(chg8), .mode(mode8)
    );

    ttl_74259_sync #(.WIDTH_OUT(6), .INIT(6'h3F)) u6 (
        .clk(clk), .reset(reset), .cen(cen), .Enable_bar(eb), .Clear_bar(cb),
        .A(a), .D(d), .Q(q6), .Q_chg(chg6), .mode(mode6)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic [2:0] aa, input logic dd);
        eb = e;
        cb = c;
        a  = aa;
        d  = dd;
    endtask

    initial begin
        #3 reset = 1'b1;
        #1;
        chk("rst_q8", q8, 8'hA5);
        chk("rst_chg8", chg8, 8'h00);
        chk("rst_mode8", mode8, 2'd0);
        chk("rst_q6", q6, 6'h3F);
        tick();
        tick();
        chk("rst_hold_q8", q8, 8'hA5);
        #4 reset = 1'b0;
        cen = 1'b1;
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mem_hold_q8", q8, 8'hA5);
        end
        drive(1'b0, 1'b1, 3'd7, 1'b0);
        tick();
        chk("oor_latch_q6", q6, 6'h3F);
        chk("oor_latch_chg6", chg6, 6'h00);
        chk("latch7_q8", q8, 8'h25);
        chk("latch7_chg8", chg8, 8'h80);
        chk("latch7_mode8", mode8, 2'd1);
        drive(1'b0, 1'b0, 3'd6, 1'b1);
        tick();
        chk("oor_demux_q6", q6, 6'h00);
        chk("oor_demux_chg6", chg6, 6'h3F);
        chk("demux6_q8", q8, 8'h40);
        chk("demux6_chg8", chg8, 8'h65);
        drive(1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        chk("clr_q8", q8, 8'h00);
        chk("clr_mode8", mode8, 2'd3);
        exp_q = 8'h00;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 3'(i), 1'b1);
            tick();
            exp_q = exp_q | (8'h01 << i);
            chk("latch_seq_q8", q8, exp_q);
            chk("latch_seq_chg8", chg8, 8'h01 << i);
            chk("latch_seq_mode8", mode8, 2'd1);
        end
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        chk("mem_after_q8", q8, 8'hFF);
        chk("mem_after_chg8", chg8, 8'h00);
        chk("mem_after_mode8", mode8, 2'd0);
        drive(1'b0, 1'b0, 3'd3, 1'b1);
        tick();
        chk("demux3_q8", q8, 8'h08);
        chk("demux3_chg8", chg8, 8'hF7);
        chk("demux3_mode8", mode8, 2'd2);
        drive(1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        chk("clr2_q8", q8, 8'h00);
        chk("clr2_chg8", chg8, 8'h08);
        chk("clr2_mode8", mode8, 2'd3);
        cen = 1'b0;
        drive(1'b0, 1'b1, 3'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cen0_q8", q8, 8'h00);
            chk("cen0_chg8", chg8, 8'h00);
            chk("cen0_mode8", mode8, 2'd3);
        end
        cen = 1'b1;
        tick();
        chk("cen1_q8", q8, 8'h04);
        chk("cen1_chg8", chg8, 8'h04);
        chk("cen1_mode8", mode8, 2'd1);
        cen = 1'b0;
        tick();
        chk("pulse_drop_chg8", chg8, 8'h00);
        chk("pulse_drop_q8", q8, 8'h04);
        cen = 1'b1;
        tick();
        chk("same_val_q8", q8, 8'h04);
        chk("same_val_chg8", chg8, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            tick();
        end
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_q8", q8, 8'hA5);
        chk("mid_rst_chg8", chg8, 8'h00);
        chk("mid_rst_mode8", mode8, 2'd0);
        chk("mid_rst_q6", q6, 6'h3F);
        drive(1'b0, 1'b1, 3'd6, 1'b1);
        #2 reset = 1'b0;
        tick();
        chk("post_rst_q8", q8, 8'hE5);
        chk("post_rst_chg8", chg8, 8'h40);
        chk("post_rst_mode8", mode8, 2'd1);
        chk("post_rst_q6", q6, 6'h3F);
        chk("post_rst_chg6", chg6, 6'h00);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
